seven_seg_bcd_driver: RTL

SEVEN_SEG_BCD_DRIVER -- requirements
Module: seven_seg_bcd_driver

---
 rtl/seven_seg_bcd_driver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_bcd_driver.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) that
// drives DIGITS active-low seven-segment patterns. Optional leading-zero
// blanking; a value needing more than DIGITS digits shows dashes and raises
// o_overflow. All outputs are registered and update together when the
// conversion finishes.
`timescale 1ns/1ps
module seven_seg_bcd_driver #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_value,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_seven
);

  localparam int            BW       = 4 * DIGITS;
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [6:0]    SEG_DARK = 7'b1111111;
  localparam logic [6:0]    SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      value_q, value_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic [7*DIGITS-1:0]   seven_q, seven_d;

  logic [BW-1:0]         bcd_adj;
  logic [7*DIGITS-1:0]   disp;
  logic                  lead_zero;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1011000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = SEG_DARK;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Segment image of the finished accumulator, scanning from the top digit down for blanking.
  always_comb begin
    disp      = '1;
    lead_zero = BLANK_LZ;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if ((bcd_q[4*k +: 4] != 4'd0) || (k == 0)) lead_zero = 1'b0;
      if (ovf_acc_q)      disp[7*k +: 7] = SEG_DASH;
      else if (lead_zero) disp[7*k +: 7] = SEG_DARK;
      else                disp[7*k +: 7] = seg_encode(bcd_q[4*k +: 4]);
    end
  end

  // Next-state logic for the IDLE -> SHIFT (WIDTH cycles) -> LOAD sequence.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_acc_d  = ovf_acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    seven_d    = seven_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = SHIFT;
          value_d   = i_value;
          bcd_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        bcd_d   = {bcd_adj[BW-2:0], value_q[WIDTH-1]};
        value_d = value_q << 1;
        // A 1 leaving the top digit means the value needs more than DIGITS digits.
        if (bcd_adj[BW-1]) ovf_acc_d = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = LOAD;
      end
      LOAD: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        overflow_d = ovf_acc_q;
        seven_d    = disp;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any conversion and darkens the display.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      value_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      seven_q    <= '1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values, regardless of statement order.
      state_q    <= state_d;
      value_q    <= value_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      seven_q    <= seven_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = overflow_q;
  assign o_seven    = seven_q;

endmodule
